// File: rtl/seq_pkg.sv
// Shared types and constants for the sequential Y86-64 stage sequencer:
// FSM state encoding, status codes, icode values and the data-memory predicate.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Instructions that touch data memory and therefore wait on mem_ack.
  function automatic logic needs_dmem(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_MRMOVQ) ||
           (icode == I_CALL)   || (icode == I_RET)    ||
           (icode == I_PUSHQ)  || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// Performance counters for the stage sequencer: active cycles and retired
// instructions, both 64-bit and wrapping.
module seq_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        busy,
  input  logic        retire,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instr_cnt
);

  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = busy   ? cycle_cnt_q + 64'd1 : cycle_cnt_q;
    instr_cnt_d = retire ? instr_cnt_q + 64'd1 : instr_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core.
// Define SEQ_PERF_CNT_EN to build the cycle/instruction counters.
module seq_stage_ctrl
  import seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_validity,
  input  logic        imem_error,
  input  logic        mem_ack,
  input  logic        dmem_error,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        memory_en,
  output logic        writeback_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instr_cnt
);

  state_e     state_q, state_d;
  logic [3:0] icode_q, icode_d;
  logic [2:0] stat_q,  stat_d;

  always_comb begin
    // NOTE: hold-current defaults before the case keep this block latch-free.
    state_d = state_q;
    icode_d = icode_q;
    stat_d  = stat_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH: begin
        icode_d = icode;
        if (imem_error) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else if (!instr_validity) begin
          state_d = S_HALTED;
          stat_d  = STAT_INS;
        end else if (icode == I_HALT) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_MEMORY;
      S_MEMORY: begin
        // Memory instructions hold here until the access completes.
        if (!needs_dmem(icode_q)) begin
          state_d = S_WRITEBACK;
        end else if (mem_ack) begin
          if (dmem_error) begin
            state_d = S_HALTED;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD:     state_d = S_FETCH;
      S_HALTED:    state_d = S_HALTED;
      default:     state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge, and all state uses <= so every
  // flop sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      icode_q <= I_NOP;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      icode_q <= icode_d;
      stat_q  <= stat_d;
    end
  end

  // Outputs depend only on registered state, never directly on inputs.
  assign fetch_en     = (state_q == S_FETCH);
  assign decode_en    = (state_q == S_DECODE);
  assign execute_en   = (state_q == S_EXECUTE);
  assign memory_en    = (state_q == S_MEMORY);
  assign writeback_en = (state_q == S_WRITEBACK);
  assign pc_en        = (state_q == S_PCUPD);
  assign mem_req      = (state_q == S_MEMORY) && needs_dmem(icode_q);
  assign busy         = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign stat         = stat_q;

`ifdef SEQ_PERF_CNT_EN
  logic retire;
  assign retire = (state_q == S_PCUPD);

  seq_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .retire    (retire),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
